// File: rtl/cmd_mem_loader.sv
// Purpose: packs a stream of MEM_WIDTH words into MEM_TO_CMD-wide commands and writes them to one selected core's command memory.
// Latency: a command's write strobe comes 1 cycle after its completing word is accepted; done comes with the final write.
// Backpressure: word_ready is high for the whole load, so the stream runs at 1 word/cycle with no stalls; ready is low in IDLE.
// Optional feature: define CMD_LOADER_CHECKSUM_EN to build the running XOR checksum; otherwise checksum is tied to 0.
module cmd_mem_loader #(
    parameter int NUM_CORES      = 2,
    parameter int CORE_SEL_WIDTH = 1,
    parameter int MEM_WIDTH      = 32,
    parameter int MEM_TO_CMD     = 4,
    parameter int CMD_ADDR_WIDTH = 16
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start,
    input  logic [CORE_SEL_WIDTH-1:0]       core_sel,
    input  logic [CMD_ADDR_WIDTH-1:0]       start_addr,
    input  logic [MEM_WIDTH-1:0]            word_in,
    input  logic                            word_valid,
    input  logic                            word_last,
    output logic                            word_ready,
    output logic [MEM_WIDTH*MEM_TO_CMD-1:0] cmd_write,
    output logic [CMD_ADDR_WIDTH-1:0]       cmd_write_addr,
    output logic [NUM_CORES-1:0]            cmd_write_enable,
    output logic                            busy,
    output logic                            done,
    output logic [CMD_ADDR_WIDTH:0]         cmd_count,
    output logic                            error,
    output logic [MEM_WIDTH-1:0]            checksum
);

    localparam int IDX_W = (MEM_TO_CMD > 1) ? $clog2(MEM_TO_CMD) : 1;

    typedef enum logic {IDLE, LOAD} state_t;

    state_t                                  state_q, state_d;
    logic [MEM_TO_CMD-1:0][MEM_WIDTH-1:0]    asm_buf, asm_next;
    logic [IDX_W-1:0]                        idx_q;
    logic [CORE_SEL_WIDTH-1:0]               core_q;
    logic [CMD_ADDR_WIDTH-1:0]               addr_q;
    logic [NUM_CORES-1:0]                    core_onehot;
    logic                                    start_ok;
    logic                                    accept;
    logic                                    cmd_complete;
    logic                                    addr_at_max;
    logic                                    core_invalid;

    assign word_ready   = (state_q == LOAD);
    assign busy         = (state_q == LOAD);
    assign start_ok     = (state_q == IDLE) && start;
    assign accept       = word_valid && word_ready;
    assign cmd_complete = accept && ((idx_q == IDX_W'(MEM_TO_CMD - 1)) || word_last);
    assign addr_at_max  = &addr_q;
    assign core_onehot  = NUM_CORES'(1) << core_q;
    assign core_invalid = ({1'b0, core_sel} >= (CORE_SEL_WIDTH + 1)'(NUM_CORES));

    // Next state: start opens a load, accepting the last word closes it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = LOAD;
            LOAD:    if (accept && word_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Assembly buffer with the current word dropped into its chunk slot;
    // slots above the index are still zero because the buffer is cleared per command.
    always_comb begin
        asm_next        = asm_buf;
        asm_next[idx_q] = word_in;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Assembly, write register, address/count tracking and sticky error.
    // The write register is separate from asm_buf so assembly of the next
    // command continues in the same cycle its predecessor is written.
    always_ff @(posedge clk) begin
        if (reset) begin
            asm_buf          <= '0;
            idx_q            <= '0;
            core_q           <= '0;
            addr_q           <= '0;
            cmd_write        <= '0;
            cmd_write_addr   <= '0;
            cmd_write_enable <= '0;
            cmd_count        <= '0;
            error            <= 1'b0;
            done             <= 1'b0;
        end else begin
            cmd_write_enable <= '0;
            done             <= 1'b0;
            if (start_ok) begin
                core_q    <= core_sel;
                addr_q    <= start_addr;
                idx_q     <= '0;
                asm_buf   <= '0;
                cmd_count <= '0;
                error     <= core_invalid;
            end else if (accept) begin
                done <= word_last;
                if (cmd_complete) begin
                    idx_q   <= '0;
                    asm_buf <= '0;
                    // Once in error, completed commands are drained silently.
                    if (!error) begin
                        cmd_write        <= asm_next;
                        cmd_write_addr   <= addr_q;
                        cmd_write_enable <= core_onehot;
                        addr_q           <= addr_q + 1'b1;
                        cmd_count        <= cmd_count + 1'b1;
                        // Top address written but the stream continues: nowhere left to put it.
                        if (addr_at_max && !word_last) error <= 1'b1;
                    end
                end else begin
                    idx_q   <= idx_q + 1'b1;
                    asm_buf <= asm_next;
                end
            end
        end
    end

`ifdef CMD_LOADER_CHECKSUM_EN
    // Running XOR of every accepted word of the current load, drained words included.
    always_ff @(posedge clk) begin
        if (reset)         checksum <= '0;
        else if (start_ok) checksum <= '0;
        else if (accept)   checksum <= checksum ^ word_in;
    end
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_cmd_mem_loader.sv
// Directed bench for cmd_mem_loader: full, partial, gapped, overflow, bad-core and mid-load reset scenarios.
// Writes and done pulses are logged on the falling edge with the rising-edge count at which they appeared.
// Inputs are driven 1 time unit after the rising edge.
module tb_cmd_mem_loader;

    localparam int NC = 2;
    localparam int CSW = 2;
    localparam int MW = 32;
    localparam int MTC = 4;
    localparam int AW = 16;

    logic                clk = 1'b0;
    logic                reset;
    logic                start;
    logic [CSW-1:0]      core_sel;
    logic [AW-1:0]       start_addr;
    logic [MW-1:0]       word_in;
    logic                word_valid;
    logic                word_last;
    logic                word_ready;
    logic [MW*MTC-1:0]   cmd_write;
    logic [AW-1:0]       cmd_write_addr;
    logic [NC-1:0]       cmd_write_enable;
    logic                busy;
    logic                done;
    logic [AW:0]         cmd_count;
    logic                error;
    logic [MW-1:0]       checksum;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_acc = 0;

    logic [NC-1:0]     wr_en[$];
    logic [AW-1:0]     wr_addr[$];
    logic [MW*MTC-1:0] wr_dat[$];
    int                wr_cyc[$];
    int                done_n = 0;
    int                done_cyc = 0;
    logic              done_busy = 1'b0;
    logic              done_rdy = 1'b0;

    cmd_mem_loader #(
        .NUM_CORES(NC), .CORE_SEL_WIDTH(CSW), .MEM_WIDTH(MW),
        .MEM_TO_CMD(MTC), .CMD_ADDR_WIDTH(AW)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .core_sel(core_sel),
        .start_addr(start_addr), .word_in(word_in), .word_valid(word_valid),
        .word_last(word_last), .word_ready(word_ready), .cmd_write(cmd_write),
        .cmd_write_addr(cmd_write_addr), .cmd_write_enable(cmd_write_enable),
        .busy(busy), .done(done), .cmd_count(cmd_count), .error(error),
        .checksum(checksum)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    always @(negedge clk) begin
        if (cmd_write_enable != '0) begin
            wr_en.push_back(cmd_write_enable);
            wr_addr.push_back(cmd_write_addr);
            wr_dat.push_back(cmd_write);
            wr_cyc.push_back(cyc);
        end
        if (done) begin
            done_n    = done_n + 1;
            done_cyc  = cyc;
            done_busy = busy;
            done_rdy  = word_ready;
        end
    end

    function automatic logic [MW*MTC-1:0] mk(input logic [MW-1:0] c0, input logic [MW-1:0] c1,
                                             input logic [MW-1:0] c2, input logic [MW-1:0] c3);
        return {c3, c2, c1, c0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        wr_en.delete(); wr_addr.delete(); wr_dat.delete(); wr_cyc.delete();
        done_n = 0;
    endtask

    task automatic do_start(input logic [CSW-1:0] c, input logic [AW-1:0] a);
        clear_log();
        core_sel = c; start_addr = a; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Sends words 1..n, last on the n-th; gap inserts an idle cycle after each word.
    task automatic send_words(input int n, input bit gap, input bit with_last);
        for (int i = 1; i <= n; i++) begin
            word_valid = 1'b1; word_in = MW'(i); word_last = with_last && (i == n);
            tick();
            last_acc = cyc;
            word_valid = 1'b0; word_last = 1'b0;
            if (gap) tick();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; core_sel = '0; start_addr = '0;
        word_in = '0; word_valid = 1'b0; word_last = 1'b0;
        tick(); tick();
        reset = 1'b0;
        tick();
        checks++; if (word_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", word_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
        checks++; if (cmd_write_enable !== 2'b00) begin errors++; $display("FAIL reset_en got %b exp 00", cmd_write_enable); end
        checks++; if (cmd_write !== '0) begin errors++; $display("FAIL reset_data got %h exp 0", cmd_write); end
        checks++; if (cmd_write_addr !== 16'h0) begin errors++; $display("FAIL reset_addr got %h exp 0", cmd_write_addr); end
        checks++; if (cmd_count !== 17'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", cmd_count); end
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL reset_error got %b exp 0", error); end
        checks++; if (checksum !== 32'h0) begin errors++; $display("FAIL reset_checksum got %h exp 0", checksum); end
    endtask

    task automatic test_full_load();
        do_start(2'd1, 16'h0010);
        checks++; if (word_ready !== 1'b1) begin errors++; $display("FAIL full_ready got %b exp 1", word_ready); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL full_busy got %b exp 1", busy); end
        send_words(8, 1'b0, 1'b1);
        tick(); tick();
        checks++; if (wr_en.size() !== 2) begin errors++; $display("FAIL full_nwr got %0d exp 2", wr_en.size()); end
        if (wr_en.size() == 2) begin
            checks++; if (wr_en[0] !== 2'b10) begin errors++; $display("FAIL full_en0 got %b exp 10", wr_en[0]); end
            checks++; if (wr_addr[0] !== 16'h0010) begin errors++; $display("FAIL full_addr0 got %h exp 0010", wr_addr[0]); end
            checks++; if (wr_dat[0] !== mk(1, 2, 3, 4)) begin errors++; $display("FAIL full_dat0 got %h exp %h", wr_dat[0], mk(1, 2, 3, 4)); end
            checks++; if (wr_addr[1] !== 16'h0011) begin errors++; $display("FAIL full_addr1 got %h exp 0011", wr_addr[1]); end
            checks++; if (wr_dat[1] !== mk(5, 6, 7, 8)) begin errors++; $display("FAIL full_dat1 got %h exp %h", wr_dat[1], mk(5, 6, 7, 8)); end
            checks++; if (wr_cyc[1] !== last_acc) begin errors++; $display("FAIL full_wr_lat got %0d exp %0d", wr_cyc[1], last_acc); end
            checks++; if (done_cyc !== wr_cyc[1]) begin errors++; $display("FAIL full_done_cyc got %0d exp %0d", done_cyc, wr_cyc[1]); end
        end
        checks++; if (done_n !== 1) begin errors++; $display("FAIL full_done_n got %0d exp 1", done_n); end
        checks++; if (done_busy !== 1'b0 || done_rdy !== 1'b0) begin errors++; $display("FAIL full_done_idle got busy=%b ready=%b exp 0 0", done_busy, done_rdy); end
        checks++; if (cmd_count !== 17'd2) begin errors++; $display("FAIL full_count got %0d exp 2", cmd_count); end
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL full_error got %b exp 0", error); end
`ifdef CMD_LOADER_CHECKSUM_EN
        checks++; if (checksum !== 32'h8) begin errors++; $display("FAIL full_checksum got %h exp 8", checksum); end
`else
        checks++; if (checksum !== 32'h0) begin errors++; $display("FAIL full_checksum got %h exp 0", checksum); end
`endif
    endtask

    task automatic test_partial();
        do_start(2'd1, 16'h0010);
        send_words(6, 1'b0, 1'b1);
        tick(); tick();
        checks++; if (wr_en.size() !== 2) begin errors++; $display("FAIL part_nwr got %0d exp 2", wr_en.size()); end
        if (wr_en.size() == 2) begin
            checks++; if (wr_addr[1] !== 16'h0011) begin errors++; $display("FAIL part_addr1 got %h exp 0011", wr_addr[1]); end
            checks++; if (wr_dat[1] !== mk(5, 6, 0, 0)) begin errors++; $display("FAIL part_dat1 got %h exp %h", wr_dat[1], mk(5, 6, 0, 0)); end
        end
        checks++; if (cmd_count !== 17'd2) begin errors++; $display("FAIL part_count got %0d exp 2", cmd_count); end
    endtask

    task automatic test_gapped();
        do_start(2'd0, 16'h0020);
        send_words(4, 1'b1, 1'b1);
        tick();
        checks++; if (wr_en.size() !== 1) begin errors++; $display("FAIL gap_nwr got %0d exp 1", wr_en.size()); end
        if (wr_en.size() == 1) begin
            checks++; if (wr_cyc[0] !== last_acc) begin errors++; $display("FAIL gap_wr_lat got %0d exp %0d", wr_cyc[0], last_acc); end
            checks++; if (wr_en[0] !== 2'b01) begin errors++; $display("FAIL gap_en got %b exp 01", wr_en[0]); end
            checks++; if (wr_dat[0] !== mk(1, 2, 3, 4)) begin errors++; $display("FAIL gap_dat got %h exp %h", wr_dat[0], mk(1, 2, 3, 4)); end
        end
    endtask

    task automatic test_overflow();
        do_start(2'd1, 16'hFFFF);
        send_words(8, 1'b0, 1'b1);
        tick(); tick();
        checks++; if (wr_en.size() !== 1) begin errors++; $display("FAIL ovf_nwr got %0d exp 1", wr_en.size()); end
        if (wr_en.size() == 1) begin
            checks++; if (wr_addr[0] !== 16'hFFFF) begin errors++; $display("FAIL ovf_addr got %h exp FFFF", wr_addr[0]); end
        end
        checks++; if (error !== 1'b1) begin errors++; $display("FAIL ovf_error got %b exp 1", error); end
        checks++; if (done_n !== 1) begin errors++; $display("FAIL ovf_done_n got %0d exp 1", done_n); end
        checks++; if (cmd_count !== 17'd1) begin errors++; $display("FAIL ovf_count got %0d exp 1", cmd_count); end
        checks++; if (cmd_write_addr !== 16'hFFFF) begin errors++; $display("FAIL ovf_hold_addr got %h exp FFFF", cmd_write_addr); end
    endtask

    task automatic test_bad_core();
        do_start(2'd3, 16'h0000);
        checks++; if (error !== 1'b1) begin errors++; $display("FAIL bad_error_early got %b exp 1", error); end
        send_words(8, 1'b0, 1'b1);
        tick(); tick();
        checks++; if (wr_en.size() !== 0) begin errors++; $display("FAIL bad_nwr got %0d exp 0", wr_en.size()); end
        checks++; if (done_n !== 1 || done_cyc !== last_acc) begin errors++; $display("FAIL bad_done got n=%0d cyc=%0d exp n=1 cyc=%0d", done_n, done_cyc, last_acc); end
        checks++; if (cmd_count !== 17'd0) begin errors++; $display("FAIL bad_count got %0d exp 0", cmd_count); end
    endtask

    task automatic test_reset_mid();
        do_start(2'd0, 16'h0030);
        send_words(2, 1'b0, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick(); tick(); tick();
        checks++; if (wr_en.size() !== 0) begin errors++; $display("FAIL rmid_nwr got %0d exp 0", wr_en.size()); end
        checks++; if (busy !== 1'b0 || word_ready !== 1'b0) begin errors++; $display("FAIL rmid_idle got busy=%b ready=%b exp 0 0", busy, word_ready); end
        checks++; if (cmd_write !== '0 || cmd_write_addr !== 16'h0) begin errors++; $display("FAIL rmid_wreg got %h@%h exp 0@0", cmd_write, cmd_write_addr); end
        checks++; if (cmd_count !== 17'd0 || error !== 1'b0 || checksum !== 32'h0) begin errors++; $display("FAIL rmid_status got cnt=%0d err=%b ck=%h exp 0 0 0", cmd_count, error, checksum); end
        do_start(2'd0, 16'h0000);
        send_words(4, 1'b0, 1'b1);
        tick();
        checks++; if (wr_en.size() !== 1) begin errors++; $display("FAIL rmid_next_nwr got %0d exp 1", wr_en.size()); end
        if (wr_en.size() == 1) begin
            checks++; if (wr_en[0] !== 2'b01 || wr_addr[0] !== 16'h0) begin errors++; $display("FAIL rmid_next_tgt got %b@%h exp 01@0000", wr_en[0], wr_addr[0]); end
            checks++; if (wr_dat[0] !== mk(1, 2, 3, 4)) begin errors++; $display("FAIL rmid_next_dat got %h exp %h", wr_dat[0], mk(1, 2, 3, 4)); end
        end
    endtask

    initial begin
        test_reset();
        test_full_load();
        test_partial();
        test_gapped();
        test_overflow();
        test_bad_core();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cmd_mem_loader.md
# cmd_mem_loader

Multi-core command-memory loader: accepts a stream of MEM_WIDTH-bit words with valid/ready handshaking, assembles every MEM_TO_CMD words into one full command, and writes it to the command memory banks of one selected processor core at auto-incrementing addresses. It sits between the host/test interface and the per-core `cmd_mem` banks of a multi-core top level. It replaces the single-core, single-cycle full-width write path.

## Interface
- NUM_CORES, 2, number of processor cores/command memories driven
- CORE_SEL_WIDTH, 1, width of core select; 2^CORE_SEL_WIDTH >= NUM_CORES
- MEM_WIDTH, 32, width of one memory bank word and of the input stream
- MEM_TO_CMD, 4, banks per command; command width = MEM_WIDTH*MEM_TO_CMD
- CMD_ADDR_WIDTH, 16, command memory address width

- clk  in  1  clock; single clock domain
- reset  in  1  synchronous, active-high reset
- start  in  1  begin a load; sampled only in IDLE
- core_sel  in  CORE_SEL_WIDTH  target core, latched on start
- start_addr  in  CMD_ADDR_WIDTH  first command address, latched on start
- word_in  in  MEM_WIDTH  stream data word
- word_valid  in  1  word_in valid
- word_last  in  1  qualifies the final word of the load
- word_ready  out  1  loader accepts word this cycle
- cmd_write  out  MEM_WIDTH*MEM_TO_CMD  assembled command; bank i takes bits [MEM_WIDTH*(i+1)-1 : MEM_WIDTH*i]
- cmd_write_addr  out  CMD_ADDR_WIDTH  write address
- cmd_write_enable  out  NUM_CORES  one-hot per-core write strobe
- busy  out  1  load in progress
- done  out  1  one-cycle pulse at end of load
- cmd_count  out  CMD_ADDR_WIDTH+1  commands written in current/last load
- error  out  1  sticky fault for current/last load
- checksum  out  MEM_WIDTH  XOR of accepted words (see Configuration)

## Operation
- States: IDLE, LOAD. Accept = word_valid && word_ready.
- IDLE: word_ready=0, busy=0. start → latch core_sel, start_addr; clear chunk index, cmd_count, error, checksum; go LOAD.
- LOAD: word_ready=1, busy=1. Each accepted word stored into chunk[idx], idx++. Chunk 0 is first word (LSBs).
- Command complete when accepted word has idx==MEM_TO_CMD-1 or word_last=1. Unfilled chunks are zero. Idx resets to 0; a write is issued the next cycle.
- Write register is separate from the assembly buffer, so throughput is 1 word/cycle with no stalls.
- After each issued write, address += 1 and cmd_count += 1.
- Accepting word_last → IDLE next cycle.
- Error cases (sticky until next start):
  - core_sel >= NUM_CORES at start: error=1; words drained, no writes.
  - Write issued at address 2^CMD_ADDR_WIDTH-1 with further words remaining: that write proceeds. error=1; subsequent commands drained, not written, not counted.
- start outside IDLE is ignored.
- Reset mid-load discards partial command; no write issued in any cycle after reset.

## Timing
- Reset values: word_ready=0, busy=0, done=0, cmd_write_enable=0, cmd_write=0, cmd_write_addr=0, cmd_count=0, error=0, checksum=0; state IDLE.
- start in cycle t → word_ready=1 at t+1.
- Completing word accepted at t → cmd_write_enable[core]=1 for exactly cycle t+1, with cmd_write/cmd_write_addr valid that cycle.
- word_last accepted at t → final write and done=1 at t+1. busy=0 and word_ready=0 at t+1.
- cmd_count and error are final when done is high.
- cmd_write/cmd_write_addr hold their last values when enable is low.

## Configuration
- CMD_LOADER_CHECKSUM_EN defined: checksum = running XOR of every accepted word since start, including drained words; cleared on start and reset; final at done.
- Not defined: checksum tied to 0; no checksum logic synthesised. Port is retained.

## Test plan
- NUM_CORES=2, start core_sel=1, start_addr=0x10, words 1..8, last on 8th:
  - enable=2'b10 at 0x10 with {4,3,2,1}, then at 0x11 with {8,7,6,5}.
  - done pulse coincides with second write; cmd_count=2; error=0.
- Partial command, words 1..6 with last on 6th:
  - second write at 0x11 = {0,0,6,5}; cmd_count=2.
- word_valid toggling every other cycle, words 1..4:
  - no write until 4th accept; single write {4,3,2,1} one cycle after it.
- start_addr=0xFFFF, words 1..8:
  - one write at 0xFFFF; error=1; second command not written; done pulses; cmd_count=1.
- core_sel=3 with NUM_CORES=2:
  - error=1; no enable bits set; done after last.
- Reset after 2 words accepted:
  - no write; all outputs at reset values.
  - Next load of words 1..4 to core 0 at addr 0 writes {4,3,2,1}.
- With CMD_LOADER_CHECKSUM_EN, words 1..8:
  - checksum=0x8 at done.
